f_div_normalize: RTL and testbench



---
 rtl/f_div_normalize_if.sv | 39 +++
 rtl/f_div_normalize.sv | 204 ++++++++++++++++++++
 tb/tb_f_div_normalize.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/f_div_normalize_if.sv
// ============================================================================
//  Module      : f_div_normalize_if
//  Description : Handshake and data bundle between the mantissa divide stage,
//                the divider output stage and the downstream consumer.
//                master = producer of quotient fields / consumer of results,
//                slave  = the normalize/round stage itself.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface f_div_normalize_if;
  // Upstream side: raw quotient fields plus the original operands
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in0;
  logic [31:0] in1;
  logic        q_sign;
  logic [9:0]  q_exp;
  logic [25:0] q_mant;
  logic        q_sticky;

  // Downstream side: final binary32 result and {nv, dz, of, uf, nx}
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;
  logic [4:0]  out_flags;

  modport master (
    output in_valid, in0, in1, q_sign, q_exp, q_mant, q_sticky, out_ready,
    input  in_ready, out_valid, out, out_flags
  );

  modport slave (
    input  in_valid, in0, in1, q_sign, q_exp, q_mant, q_sticky, out_ready,
    output in_ready, out_valid, out, out_flags
  );
endinterface

`default_nettype wire

// File: rtl/f_div_normalize.sv
// ============================================================================
//  Module      : f_div_normalize
//  Description : Output stage of the binary32 divider. Stage 1 classifies the
//                original operands for special cases and normalizes the raw
//                quotient; stage 2 rounds, applies overflow/underflow (FTZ)
//                and registers the final result and {nv,dz,of,uf,nx} flags.
//                Valid/ready pipeline with a global stall.
//  Config      : F_DIV_RNE_EN defined   -> round to nearest, ties to even
//                F_DIV_RNE_EN undefined -> truncation; overflow saturates to
//                                          the signed max finite value
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module f_div_normalize (
  input  wire logic        clk,
  input  wire logic        rstn,
  f_div_normalize_if.slave bus
);

  localparam logic [31:0] QNAN      = 32'h7FC0_0000;
  localparam logic [7:0]  EXP_ONES  = 8'hFF;
  localparam logic [4:0]  FLAGS_NV  = 5'b10000;
  localparam logic [4:0]  FLAGS_DZ  = 5'b01000;
  localparam logic [4:0]  FLAGS_OF  = 5'b00101;
  localparam logic [4:0]  FLAGS_UF  = 5'b00011;
  localparam logic [4:0]  FLAGS_NONE = 5'b00000;
  localparam logic signed [10:0] EXP_OVF = 11'sd255;
  localparam logic signed [10:0] EXP_UNF = 11'sd0;

  // --------------------------------------------------------------------------
  // Global stall: the whole pipe freezes while a result waits downstream.
  // --------------------------------------------------------------------------
  logic stall;
  assign stall        = bus.out_valid & ~bus.out_ready;
  assign bus.in_ready = ~stall;

  // --------------------------------------------------------------------------
  // Operand classification (subnormals are treated as zero)
  // --------------------------------------------------------------------------
  logic a_zero, a_inf, a_nan;
  logic b_zero, b_inf, b_nan;
  logic op_sign;

  assign a_zero  = (bus.in0[30:23] == 8'h00);
  assign a_inf   = (bus.in0[30:23] == EXP_ONES) && (bus.in0[22:0] == 23'h0);
  assign a_nan   = (bus.in0[30:23] == EXP_ONES) && (bus.in0[22:0] != 23'h0);
  assign b_zero  = (bus.in1[30:23] == 8'h00);
  assign b_inf   = (bus.in1[30:23] == EXP_ONES) && (bus.in1[22:0] == 23'h0);
  assign b_nan   = (bus.in1[30:23] == EXP_ONES) && (bus.in1[22:0] != 23'h0);
  assign op_sign = bus.in0[31] ^ bus.in1[31];

  logic        sp_hit;
  logic [31:0] sp_res;
  logic [4:0]  sp_flags;

  // Resolve special cases in priority order; a hit bypasses the quotient path
  always_comb begin
    sp_hit   = 1'b1;
    sp_res   = 32'h0;
    sp_flags = FLAGS_NONE;
    if (a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf)) begin
      sp_res   = QNAN;
      sp_flags = FLAGS_NV;
    end else if (b_zero & ~a_inf) begin
      // finite nonzero / zero
      sp_res   = {op_sign, EXP_ONES, 23'h0};
      sp_flags = FLAGS_DZ;
    end else if (a_inf) begin
      // inf / finite (including zero) is an exact infinity
      sp_res   = {op_sign, EXP_ONES, 23'h0};
    end else if (a_zero | b_inf) begin
      sp_res   = {op_sign, 31'h0};
    end else begin
      sp_hit   = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Normalization: q_mant is in [0.5,2); bring the leading one to bit 25
  // --------------------------------------------------------------------------
  logic signed [10:0] q_exp_ext;
  logic signed [10:0] n_exp;
  logic [22:0]        n_frac;
  logic               n_guard;
  logic               n_sticky;

  assign q_exp_ext = {bus.q_exp[9], bus.q_exp};

  // Select the normalized exponent, fraction, guard and sticky bits
  always_comb begin
    if (bus.q_mant[25]) begin
      n_exp    = q_exp_ext;
      n_frac   = bus.q_mant[24:2];
      n_guard  = bus.q_mant[1];
      n_sticky = bus.q_mant[0] | bus.q_sticky;
    end else begin
      n_exp    = q_exp_ext - 11'sd1;
      n_frac   = bus.q_mant[23:1];
      n_guard  = bus.q_mant[0];
      n_sticky = bus.q_sticky;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 1 registers
  // --------------------------------------------------------------------------
  logic               s1_valid;
  logic               s1_special;
  logic [31:0]        s1_sp_res;
  logic [4:0]         s1_sp_flags;
  logic               s1_sign;
  logic signed [10:0] s1_exp;
  logic [22:0]        s1_frac;
  logic               s1_guard;
  logic               s1_sticky;

  // Capture the normalized quotient and special-case verdict unless stalled
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid    <= 1'b0;
      s1_special  <= 1'b0;
      s1_sp_res   <= 32'h0;
      s1_sp_flags <= FLAGS_NONE;
      s1_sign     <= 1'b0;
      s1_exp      <= 11'sd0;
      s1_frac     <= 23'h0;
      s1_guard    <= 1'b0;
      s1_sticky   <= 1'b0;
    end else if (!stall) begin
      s1_valid    <= bus.in_valid;
      s1_special  <= sp_hit;
      s1_sp_res   <= sp_res;
      s1_sp_flags <= sp_flags;
      s1_sign     <= bus.q_sign;
      s1_exp      <= n_exp;
      s1_frac     <= n_frac;
      s1_guard    <= n_guard;
      s1_sticky   <= n_sticky;
    end
  end

  // --------------------------------------------------------------------------
  // Rounding
  // --------------------------------------------------------------------------
  logic               rnd_inc;
  logic [23:0]        frac_sum;
  logic signed [10:0] rnd_exp;
  logic               inexact;

`ifdef F_DIV_RNE_EN
  assign rnd_inc = s1_guard & (s1_sticky | s1_frac[0]);
`else
  assign rnd_inc = 1'b0;
`endif

  // A carry out of the fraction leaves frac=0 and bumps the exponent
  assign frac_sum = {1'b0, s1_frac} + {23'h0, rnd_inc};
  assign rnd_exp  = s1_exp + $signed({10'h0, frac_sum[23]});
  assign inexact  = s1_guard | s1_sticky;

`ifdef F_DIV_RNE_EN
  localparam logic [30:0] OVF_MAG = {EXP_ONES, 23'h0};
`else
  localparam logic [30:0] OVF_MAG = {8'hFE, 23'h7FFFFF};
`endif

  logic [31:0] res_out;
  logic [4:0]  res_flags;

  // Pick special, overflow, underflow (flush to zero) or the rounded normal
  always_comb begin
    res_out   = {s1_sign, rnd_exp[7:0], frac_sum[22:0]};
    res_flags = {4'b0000, inexact};
    if (s1_special) begin
      res_out   = s1_sp_res;
      res_flags = s1_sp_flags;
    end else if (rnd_exp >= EXP_OVF) begin
      res_out   = {s1_sign, OVF_MAG};
      res_flags = FLAGS_OF;
    end else if (rnd_exp <= EXP_UNF) begin
      res_out   = {s1_sign, 31'h0};
      res_flags = FLAGS_UF;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2 (output) registers; held stable while the consumer stalls
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.out_valid <= 1'b0;
      bus.out       <= 32'h0;
      bus.out_flags <= FLAGS_NONE;
    end else if (!stall) begin
      bus.out_valid <= s1_valid;
      bus.out       <= res_out;
      bus.out_flags <= res_flags;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_f_div_normalize.sv
// ============================================================================
//  Module      : tb_f_div_normalize
//  Description : Directed self-checking bench for f_div_normalize with a
//                value-level reference model and an in-order scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_f_div_normalize;

`ifdef F_DIV_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  f_div_normalize_if bus ();

  f_div_normalize dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int popped = 0;
  int stall_cycles = 0;
  bit lat_chk = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] o;
    logic [4:0]  f;
    int          acc;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    int          qe;
    logic [25:0] qm;
    logic        qs;
    logic [31:0] eo;
    logic [4:0]  ef;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Value-level reference: classify, scale the quotient into [1,2), round
  // on the bits below the 24-bit significand, then apply range limits.
  function automatic logic [36:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input int qe, input logic [25:0] qm, input logic qs);
    int     ea, eb, e, r;
    bit     a_zero, a_inf, a_nan, b_zero, b_inf, b_nan, nx;
    logic   s;
    longint m, sig;
    logic [7:0]  e8;
    logic [22:0] f23;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    a_zero = (ea == 0);
    b_zero = (eb == 0);
    a_inf  = (ea == 255) && (a[22:0] == 0);
    b_inf  = (eb == 255) && (b[22:0] == 0);
    a_nan  = (ea == 255) && (a[22:0] != 0);
    b_nan  = (eb == 255) && (b[22:0] != 0);
    s = a[31] ^ b[31];
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) return {32'h7FC00000, 5'b10000};
    if (b_zero && !a_inf) return {s, 8'hFF, 23'h0, 5'b01000};
    if (a_inf)            return {s, 8'hFF, 23'h0, 5'b00000};
    if (a_zero || b_inf)  return {s, 31'h0, 5'b00000};
    m = longint'(qm);
    e = qe;
    if (m < 64'd33554432) begin
      m = m * 2;
      e = e - 1;
    end
    sig = m / 4;
    r   = int'((m / 2) % 2) * 2 + (((m % 2) != 0 || qs) ? 1 : 0);
    nx  = (r != 0);
    if (RNE && (r == 3 || (r == 2 && (sig % 2) == 1))) sig = sig + 1;
    if (sig == 64'd16777216) begin
      sig = sig / 2;
      e   = e + 1;
    end
    if (e >= 255) return RNE ? {s, 8'hFF, 23'h0, 5'b00101} : {s, 8'hFE, 23'h7FFFFF, 5'b00101};
    if (e <= 0)   return {s, 31'h0, 5'b00011};
    e8  = e[7:0];
    f23 = sig[22:0];
    return {s, e8, f23, 4'b0000, nx};
  endfunction

  // Scoreboard and protocol checker, sampled on the falling edge
  logic [31:0] held_o;
  logic [4:0]  held_f;
  bit          stalled_prev = 1'b0;

  initial begin
    sb_t ent;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        stalled_prev = 1'b0;
      end else begin
        if (stalled_prev)
          chk("hold", {bus.out_valid, bus.out, bus.out_flags}, {1'b1, held_o, held_f});
        if (bus.out_valid && !bus.out_ready) begin
          stall_cycles++;
          chk("in_ready_stall", bus.in_ready, 1'b0);
          held_o = bus.out;
          held_f = bus.out_flags;
          stalled_prev = 1'b1;
        end else begin
          stalled_prev = 1'b0;
        end
        if (bus.out_valid && bus.out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious: got out_valid with out=%h, expected no result", bus.out);
          end else begin
            ent = sb.pop_front();
            popped++;
            chk("result", {bus.out, bus.out_flags}, {ent.o, ent.f});
            if (lat_chk) chk("latency", cyc - ent.acc, 2);
          end
        end
        if (bus.in_valid && bus.in_ready) begin
          logic [36:0] mv;
          mv = model(bus.in0, bus.in1, int'($signed(bus.q_exp)), bus.q_mant, bus.q_sticky);
          sb.push_back('{o: mv[36:5], f: mv[4:0], acc: cyc});
        end
      end
    end
  end

  task automatic send(input int i);
    int n;
    bit ok;
    int q;
    q  = vecs[i].qe;
    n  = 0;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in0      = vecs[i].a;
    bus.in1      = vecs[i].b;
    bus.q_sign   = vecs[i].a[31] ^ vecs[i].b[31];
    bus.q_exp    = q[9:0];
    bus.q_mant   = vecs[i].qm;
    bus.q_sticky = vecs[i].qs;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      n++;
    end
    #1;
    if (!ok) fail_now("send_timeout");
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.out_valid) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 50) fail_now("drain_timeout");
  endtask

  task automatic add(input logic [31:0] a, input logic [31:0] b, input int qe,
                     input logic [25:0] qm, input logic qs,
                     input logic [31:0] eo, input logic [4:0] ef);
    vecs.push_back('{a: a, b: b, qe: qe, qm: qm, qs: qs, eo: eo, ef: ef});
  endtask

  initial begin
    int base;
    int n;
    logic [36:0] mv;

    bus.in_valid  = 1'b0;
    bus.in0       = 32'h0;
    bus.in1       = 32'h0;
    bus.q_sign    = 1'b0;
    bus.q_exp     = 10'h0;
    bus.q_mant    = 26'h0;
    bus.q_sticky  = 1'b0;
    bus.out_ready = 1'b1;

    // Hand-computed vectors: in0, in1, q_exp, q_mant, q_sticky, out, flags
    add(32'h40C00000, 32'h40000000, 128, 26'h3000000, 1'b0, 32'h40400000, 5'h00);
    add(32'h3F800000, 32'h40400000, 126, 26'h1555555, 1'b1, RNE ? 32'h3EAAAAAB : 32'h3EAAAAAA, 5'h01);
    add(32'h3F800000, 32'h00000000, 0, 26'h0, 1'b0, 32'h7F800000, 5'h08);
    add(32'h00000000, 32'h00000000, 0, 26'h0, 1'b0, 32'h7FC00000, 5'h10);
    add(32'hC0000000, 32'h7F800000, 0, 26'h0, 1'b0, 32'h80000000, 5'h00);
    add(32'h7FC00000, 32'h3F800000, 0, 26'h0, 1'b0, 32'h7FC00000, 5'h10);
    add(32'h3F800000, 32'h3F800000, 255, 26'h2000000, 1'b0, RNE ? 32'h7F800000 : 32'h7F7FFFFF, 5'h05);
    add(32'h3F800000, 32'h3F800000, 0, 26'h2000000, 1'b0, 32'h00000000, 5'h03);
    add(32'h3F800000, 32'h3F800000, 254, 26'h3FFFFFF, 1'b0, RNE ? 32'h7F800000 : 32'h7F7FFFFF, RNE ? 5'h05 : 5'h01);
    add(32'h7F800000, 32'h40000000, 0, 26'h0, 1'b0, 32'h7F800000, 5'h00);
    add(32'hFF800000, 32'h40000000, 0, 26'h0, 1'b0, 32'hFF800000, 5'h00);
    add(32'h40000000, 32'h80000000, 0, 26'h0, 1'b0, 32'hFF800000, 5'h08);
    add(32'h7F800000, 32'hFF800000, 0, 26'h0, 1'b0, 32'h7FC00000, 5'h10);
    add(32'h00000001, 32'h3F800000, 0, 26'h0, 1'b0, 32'h00000000, 5'h00);
    add(32'h3F800000, 32'h3F800000, 127, 26'h2000002, 1'b0, 32'h3F800000, 5'h01);
    add(32'h3F800000, 32'h3F800000, 127, 26'h2000006, 1'b0, RNE ? 32'h3F800002 : 32'h3F800001, 5'h01);
    add(32'hBF800000, 32'h3F800000, 127, 26'h2000000, 1'b0, 32'hBF800000, 5'h00);
    add(32'h3F800000, 32'h3F800000, 1, 26'h2000000, 1'b0, 32'h00800000, 5'h00);
    add(32'h3F800000, 32'h3F800000, 1, 26'h1000000, 1'b0, 32'h00000000, 5'h03);
    add(32'h3F800000, 32'h3F800000, -127, 26'h3000000, 1'b0, 32'h00000000, 5'h03);
    add(32'hC0000000, 32'h3F800000, 381, 26'h2000000, 1'b0, RNE ? 32'hFF800000 : 32'hFF7FFFFF, 5'h05);
    add(32'h3F800000, 32'h00000001, 0, 26'h0, 1'b0, 32'h7F800000, 5'h08);
    add(32'h00000000, 32'h40A00000, 0, 26'h0, 1'b0, 32'h00000000, 5'h00);
    add(32'h3F800000, 32'h7F800000, 0, 26'h0, 1'b0, 32'h00000000, 5'h00);

    // Pin the reference model to the hand-computed values
    foreach (vecs[i]) begin
      mv = model(vecs[i].a, vecs[i].b, vecs[i].qe, vecs[i].qm, vecs[i].qs);
      chk($sformatf("model_%0d", i), mv, {vecs[i].eo, vecs[i].ef});
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {bus.out_valid, bus.in_ready, bus.out, bus.out_flags}, {1'b0, 1'b1, 32'h0, 5'h0});
    rstn = 1'b1;
    chk("in_ready_after_release", bus.in_ready, 1'b1);

    // Directed vectors streamed back to back, then with a bubble
    lat_chk = 1'b1;
    base = popped;
    foreach (vecs[i]) send(i);
    idle();
    drain();
    chk("directed_count", popped - base, vecs.size());

    send(0);
    idle();
    @(posedge clk);
    #1;
    send(1);
    idle();
    drain();

    // Backpressure: 4 operands, out_ready low for 3 cycles after first result
    lat_chk = 1'b0;
    base = popped;
    stall_cycles = 0;
    fork
      begin
        for (int k = 0; k < 4; k++) send(k);
        idle();
      end
      begin
        n = 0;
        while (!bus.out_valid && n < 50) begin
          @(posedge clk);
          #1;
          n++;
        end
        if (n >= 50) fail_now("bp_wait_valid");
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_delivered", popped - base, 4);
    chk("bp_stall_cycles", stall_cycles, 3);

    // Reset with two results in flight
    lat_chk = 1'b1;
    send(0);
    send(1);
    idle();
    #1;
    rstn = 1'b0;
    #1;
    chk("async_reset", {bus.out_valid, bus.out, bus.out_flags}, {1'b0, 32'h0, 5'h0});
    sb.delete();
    @(negedge clk);
    #2;
    rstn = 1'b1;
    #1;
    chk("in_ready_after_rst", bus.in_ready, 1'b1);
    @(posedge clk);
    #1;
    base = popped;
    send(0);
    idle();
    chk("post_rst_cycle1", bus.out_valid, 1'b0);
    @(posedge clk);
    #1;
    chk("post_rst_cycle2", {bus.out_valid, bus.out, bus.out_flags}, {1'b1, 32'h40400000, 5'h00});
    drain();
    chk("post_rst_count", popped - base, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected completion before 200000");
    $fatal(1);
  end

endmodule

`default_nettype wire
